// File: rtl/sw_db_pkg.sv
// Shared defaults and width helper for the slide-switch debouncer.
package sw_db_pkg;

    localparam int SW_WIDTH        = 16;
    localparam int SW_TICK_DIV     = 100000;
    localparam int SW_STABLE_TICKS = 10;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } bit_state_t;

    // Bits needed to hold every value 0..max_val (never less than 1).
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sw_db_bit.sv
// One switch channel: 2-flop synchronizer, stability counter, level and edge pulses.
// With SW_DB_BYPASS_EN defined the counter is dropped and the level follows sync after one flop.
module sw_db_bit
    import sw_db_pkg::*;
#(
    parameter int STABLE_TICKS = SW_STABLE_TICKS,
    parameter int CW           = width_for(SW_STABLE_TICKS)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    input  logic tick,
    output logic db,
    output logic rise,
    output logic fall,
    output logic accept
);

    logic [1:0] sync_q;
    logic       sync;
    bit_state_t state;

    assign sync  = sync_q[1];
    assign state = (sync != db) ? ST_PENDING : ST_STABLE;

`ifdef SW_DB_BYPASS_EN

    // Registered level tracks sync directly; tick is not used in this build.
    assign accept = (state == ST_PENDING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            db     <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sw};
            db     <= sync;
            rise   <= accept & sync;
            fall   <= accept & ~sync;
        end
    end

`else

    logic [CW-1:0] cnt;

    // Accept on the tick that completes the required run of mismatching ticks.
    assign accept = (state == ST_PENDING) && tick && (cnt == CW'(STABLE_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            cnt    <= '0;
            db     <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], sw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (state == ST_STABLE) begin
                cnt <= '0;
            end else if (accept) begin
                db   <= sync;
                cnt  <= '0;
                rise <= sync;
                fall <= ~sync;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: shared sample-tick prescaler, per-bit debounce, change strobe.
// Define SW_DB_BYPASS_EN to skip debouncing (sync + one register) for fast simulation.
module sw_debounce
    import sw_db_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = SW_TICK_DIV,
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam int CW = width_for(STABLE_TICKS);

    logic             tick;
    logic [WIDTH-1:0] accept;

`ifdef SW_DB_BYPASS_EN
    assign tick = 1'b0;
`else
    localparam int PW = width_for(TICK_DIV - 1);

    logic [PW-1:0] pcnt;

    // Starts at 0 out of reset, so the first tick lands TICK_DIV-1 cycles after release.
    assign tick = (pcnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_db_bit #(
            .STABLE_TICKS(STABLE_TICKS),
            .CW          (CW)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .sw    (SW[i]),
            .tick  (tick),
            .db    (sw_db[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i]),
            .accept(accept[i])
        );
    end

    // Built from the per-bit accept terms so it lands in the same cycle as rise/fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |accept;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Randomized bench for sw_debounce with a tick-counting reference model and per-cycle scoreboard.
module tb_sw_debounce;

    localparam int W  = 16;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw  = '0;
    logic [W-1:0] sw_db, sw_rise, sw_fall;
    logic         sw_changed;

    int checks = 0;
    int errors = 0;

    logic [3*W:0] exp_q[$];

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH       (W),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SW        (sw),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: edge index e counts clk edges since reset release, sync is SW two
    // edges back, ticks fall on edges with e%TD==TD-1. A bit is accepted on the edge where
    // the number of ticks seen since it started mismatching reaches ST.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_db = '0;
    int           e = 0;
    int           pend_start[W];

    always @(posedge clk) begin : model
        logic [W-1:0] sync, rise, fall;
        rise = '0;
        fall = '0;
        if (rst) begin
            m_db = '0;
            e    = 0;
            hist.delete();
            for (int i = 0; i < W; i++) pend_start[i] = -1;
            exp_q.push_back('0);
        end else begin
            sync = (e >= 2) ? hist[e-2] : '0;
            for (int i = 0; i < W; i++) begin
                if (sync[i] != m_db[i]) begin
                    if (pend_start[i] < 0) pend_start[i] = e;
                    if ((e + 1) / TD - pend_start[i] / TD == ST) begin
                        m_db[i]       = sync[i];
                        rise[i]       = sync[i];
                        fall[i]       = ~sync[i];
                        pend_start[i] = -1;
                    end
                end else begin
                    pend_start[i] = -1;
                end
            end
            hist.push_back(sw);
            e++;
            exp_q.push_back({|(rise | fall), fall, rise, m_db});
        end
    end

    always @(posedge clk) begin : monitor
        logic [3*W:0] exp;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t got=0 entries expected>=1", $time);
        end else begin
            exp = exp_q.pop_front();
            cmp("sw_db", sw_db, exp[W-1:0]);
            cmp("sw_rise", sw_rise, exp[2*W-1:W]);
            cmp("sw_fall", sw_fall, exp[3*W-1:2*W]);
            cmp("sw_changed", {{(W-1){1'b0}}, sw_changed}, {{(W-1){1'b0}}, exp[3*W]});
        end
    end

    task automatic drive(input logic [W-1:0] v);
        @(negedge clk);
        sw = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges from the last drive until sw_db[idx] reaches val.
    task automatic latency_check(input string name, input int idx, input logic val,
                                 input int lo, input int hi);
        int n = 0;
        while (n < 30) begin
            @(posedge clk);
            #2;
            n++;
            if (sw_db[idx] == val) break;
        end
        checks++;
        if (n < lo || n > hi || sw_db[idx] != val) begin
            errors++;
            $display("FAIL %s latency got=%0d expected=%0d..%0d", name, n, lo, hi);
        end
        @(negedge clk);
    endtask

    task automatic wait_pulse(input string name, input logic [W-1:0] er, input logic [W-1:0] ef);
        int  n    = 0;
        logic seen = 1'b0;
        while (n < 30 && !seen) begin
            @(posedge clk);
            #2;
            n++;
            seen = sw_changed;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_pulse got=none expected=pulse within 30 clk", name);
        end else begin
            cmp({name, "_rise"}, sw_rise, er);
            cmp({name, "_fall"}, sw_fall, ef);
            @(posedge clk);
            #2;
            cmp({name, "_single"}, {{(W-1){1'b0}}, sw_changed}, '0);
        end
        @(negedge clk);
    endtask

    initial begin : driver
        logic [W-1:0] v;
        rst = 1'b1;
        sw  = '0;
        idle(3);
        rst = 1'b0;
        idle(50);

        drive(16'h0001);
        latency_check("rise0", 0, 1'b1, 11, 14);
        idle(20);

        drive(16'h0011); idle(2);
        drive(16'h0001); idle(2);
        drive(16'h0011); idle(2);
        drive(16'h0001); idle(2);
        drive(16'h0011);
        latency_check("rise4_after_bounce", 4, 1'b1, 11, 14);
        idle(20);

        drive(16'h0000);
        idle(25);
        drive(16'hFFFF);
        wait_pulse("all_rise", 16'hFFFF, 16'h0000);
        idle(20);
        drive(16'h0000);
        wait_pulse("all_fall", 16'h0000, 16'hFFFF);
        idle(20);

        drive(16'h8000);
        idle(9);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        latency_check("rise15_after_reset", 15, 1'b1, 12, 12);
        idle(20);

        for (int k = 0; k < 700; k++) begin
            v = sw;
            if ($urandom_range(0, 99) == 0) v = W'($urandom);
            else if ($urandom_range(0, 7) == 0) v = v ^ (W'(1) << $urandom_range(0, W - 1));
            drive(v);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
